// File: rtl/load_store_unit.sv
// Memory-stage load/store unit for the RV32I pipeline: drives a req/gnt/rvalid
// data port, formats store lanes and strobes, and aligns/extends load data.

package riscv_pkg;
   localparam int XLEN = 32;

   typedef enum logic [4:0] {
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW,
      OP_JAL, OP_BEQ
   } operation_e;
endpackage

module load_store_unit
   import riscv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   input  operation_e      operation_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] store_data_i,
   output logic            busy_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [3:0]      mem_wstrb_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic [XLEN-1:0] mem_data_o,
   output logic            done_o,
   output logic            misaligned_o,
   output logic            bus_err_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_e           state;
   operation_e       op_q;
   logic [1:0]       addr_q;
   logic [CW-1:0]    cnt;

   logic             is_load;
   logic             is_store;
   logic             misaligned;
   logic             timeout;
   logic [XLEN-1:0]  wdata_fmt;
   logic [3:0]       wstrb_fmt;
   logic [7:0]       rbyte;
   logic [15:0]      rhalf;
   logic [XLEN-1:0]  load_val;

   assign busy_o = (state != IDLE);

   // The count of cycles already spent reaches TIMEOUT_CYCLES at this edge.
   assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

   always_comb begin
      is_load    = operation_i inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
      is_store   = operation_i inside {OP_SB, OP_SH, OP_SW};
      misaligned = ((operation_i inside {OP_LW, OP_SW}) && (addr_i[1:0] != 2'b00)) ||
                   ((operation_i inside {OP_LH, OP_LHU, OP_SH}) && addr_i[0]);
      wdata_fmt  = store_data_i;
      wstrb_fmt  = 4'b0000;
      case (operation_i)
         OP_SB: begin
            wdata_fmt = {4{store_data_i[7:0]}};
            wstrb_fmt = 4'b0001 << addr_i[1:0];
         end
         OP_SH: begin
            wdata_fmt = {2{store_data_i[15:0]}};
            wstrb_fmt = 4'b0011 << addr_i[1:0];
         end
         OP_SW: begin
            wdata_fmt = store_data_i;
            wstrb_fmt = 4'b1111;
         end
         default: ;
      endcase
   end

   always_comb begin
      rbyte    = mem_rdata_i[{addr_q, 3'b000} +: 8];
      rhalf    = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
      load_val = mem_rdata_i;
      case (op_q)
         OP_LB:   load_val = {{24{rbyte[7]}}, rbyte};
         OP_LBU:  load_val = {24'd0, rbyte};
         OP_LH:   load_val = {{16{rhalf[15]}}, rhalf};
         OP_LHU:  load_val = {16'd0, rhalf};
         default: load_val = mem_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         op_q         <= OP_NOP;
         addr_q       <= 2'b00;
         cnt          <= '0;
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
         mem_wstrb_o  <= 4'b0000;
         mem_data_o   <= '0;
         done_o       <= 1'b0;
         misaligned_o <= 1'b0;
         bus_err_o    <= 1'b0;
      end else begin
         done_o       <= 1'b0;
         misaligned_o <= 1'b0;
         bus_err_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_i && (is_load || is_store)) begin
                  if (misaligned) begin
                     misaligned_o <= 1'b1;
                     done_o       <= 1'b1;
                  end else begin
                     op_q        <= operation_i;
                     addr_q      <= addr_i[1:0];
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= is_store;
                     mem_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
                     mem_wdata_o <= wdata_fmt;
                     mem_wstrb_o <= wstrb_fmt;
                     cnt         <= '0;
                     state       <= REQ;
                  end
               end
            end
            REQ: begin
               // A grant in the final watchdog cycle still completes the access.
               if (mem_gnt_i) begin
                  mem_req_o <= 1'b0;
                  cnt       <= '0;
                  if (mem_we_o) begin
                     done_o <= 1'b1;
                     state  <= IDLE;
                  end else begin
                     state  <= WAIT_RSP;
                  end
               end else if (timeout) begin
                  mem_req_o  <= 1'b0;
                  mem_data_o <= '0;
                  bus_err_o  <= 1'b1;
                  done_o     <= 1'b1;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WAIT_RSP: begin
               if (mem_rvalid_i) begin
                  mem_data_o <= load_val;
                  done_o     <= 1'b1;
                  state      <= IDLE;
               end else if (timeout) begin
                  mem_data_o <= '0;
                  bus_err_o  <= 1'b1;
                  done_o     <= 1'b1;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block of the RV32I pipeline. It is the producer of the load data that the writeback stage selects for LW/LH/LB/LHU/LBU.
- Takes a decoded memory operation plus its effective address and store data, and drives a req/gnt/rvalid data-memory port.
- Aligns and sign- or zero-extends load data; builds store byte strobes.
- Raises busy_o so the pipeline stalls while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in REQ or WAIT_RSP before abort; 0 disables the watchdog.
(XLEN comes from riscv_pkg and is fixed at 32.)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
valid_i  input  1  operation presented this cycle
operation_i  input  operation_e  decoded op (riscv_pkg)
addr_i  input  XLEN  effective byte address
store_data_i  input  XLEN  rs2 value for stores
busy_o  output  1  access in flight; pipeline must hold inputs/stall
mem_req_o  output  1  memory request
mem_we_o  output  1  1 = store
mem_addr_o  output  XLEN  word-aligned address ({addr[31:2],2'b00})
mem_wdata_o  output  XLEN  lane-replicated store data
mem_wstrb_o  output  4  byte strobes
mem_gnt_i  input  1  request accepted
mem_rvalid_i  input  1  load response valid
mem_rdata_i  input  XLEN  load response word
mem_data_o  output  XLEN  extended load result, to writeback
done_o  output  1  one-cycle completion pulse
misaligned_o  output  1  one-cycle misalignment pulse
bus_err_o  output  1  one-cycle watchdog-timeout pulse

Behaviour:
- Clock and reset: one clock domain, clk_i. rst_i is synchronous and active-high.
- Reset values: state = IDLE; all outputs 0; mem_data_o = 0; timeout counter = 0.
- Memory ops: LB, LH, LW, LBU, LHU, SB, SH, SW. Any other operation_i is ignored (no state change, no pulses).
- busy_o = (state != IDLE), combinational.
- States:
  - IDLE: on valid_i with a memory op:
    - Misaligned (LW/SW with addr[1:0] != 0; LH/LHU/SH with addr[0] != 0): stay in IDLE, issue no request, pulse misaligned_o and done_o the next cycle.
    - Otherwise: register op, addr and data, and go to REQ.
  - REQ: mem_req_o = 1 and all mem_* outputs held stable until mem_gnt_i.
    - On gnt with a store: go to IDLE and pulse done_o the next cycle.
    - On gnt with a load: go to WAIT_RSP; mem_req_o drops the next cycle.
  - WAIT_RSP: on mem_rvalid_i, latch the extracted value into mem_data_o, pulse done_o the next cycle, and go to IDLE.
- Minimum latency:
  - Store: valid_i at cycle 0, req at cycle 1, gnt at cycle 1, done_o at cycle 2.
  - Load: gnt at cycle 1, rvalid at cycle 2, done_o at cycle 3.
- gnt and rvalid in the same cycle while in REQ are not legal for this port. rvalid in IDLE or REQ is ignored.
- Store formatting:
  - SB: wdata = {4{data[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}, wstrb = 4'b0011 << addr[1:0].
  - SW: wdata = data, wstrb = 4'b1111.
- Loads use mem_we_o = 0 and wstrb = 0.
- Load extraction:
  - byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW takes the full word.
- mem_data_o holds its value until the next completed load. Stores and misaligned or aborted accesses do not change it, except that a timeout clears it to 0.
- Watchdog:
  - The counter clears on entry to REQ and on entry to WAIT_RSP, and increments each cycle spent in those states.
  - When it reaches TIMEOUT_CYCLES (if nonzero): go to IDLE, drop mem_req_o, set mem_data_o = 0, and pulse bus_err_o and done_o.
- Reset mid-operation: returns to IDLE at that edge, and mem_req_o is 0 the following cycle. A late rvalid after reset is ignored.
- Pulses: done_o, misaligned_o and bus_err_o are high for exactly one cycle per event and never overlap with another access's done_o.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, gnt immediate -> mem_addr_o=0x100, wstrb=1111, wdata=0xDEADBEEF, we=1; done_o exactly at cycle 2.
- SB addr=0x103, data=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5. SH addr=0x102, data=0x1234 -> wstrb=1100, wdata=0x12341234.
- rdata=0x80F0_7F81 with LB@0x200 -> 0xFFFFFF81; LBU@0x200 -> 0x00000081; LH@0x202 -> 0xFFFF80F0; LHU@0x202 -> 0x000080F0; LW -> 0x80F07F81.
- gnt delayed 3 cycles, rvalid delayed 2 more -> mem_req_o high and mem_addr_o stable through the wait; busy_o high throughout; single done_o.
- LW@0x101 and SH@0x201 -> no mem_req_o, misaligned_o and done_o pulse once, busy_o stays 0.
- TIMEOUT_CYCLES=4, load granted, rvalid never arrives -> bus_err_o and done_o after 4 cycles in WAIT_RSP, mem_data_o=0. Separately, rst_i asserted in REQ -> IDLE, mem_req_o=0 next cycle, a subsequent stray rvalid is ignored.
